lc4_seq_divider: RTL and testbench
==================================

LC4_SEQ_DIVIDER -- requirements
Module: lc4_seq_divider

Interface
REQ-001 The block SHALL have parameter W, default 16, giving the operand width in bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1, request to begin a division.
REQ-005 The block SHALL have port dividend, input, W, unsigned numerator, sampled on the accepting edge only.
REQ-006 The block SHALL have port divisor, input, W, unsigned denominator, sampled on the accepting edge only.
REQ-007 The block SHALL have port busy, output, 1, high while an accepted division is iterating.
REQ-008 The block SHALL have port done, output, 1, single-cycle pulse marking that the results are valid.
REQ-009 The block SHALL have port quotient, output, W, registered result.
REQ-010 The block SHALL have port remainder, output, W, registered result.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-012 A start sampled high in IDLE or DONE SHALL be accepted; the FSM SHALL go to RUN with iteration count 0 and latch dividend and divisor.
REQ-013 start SHALL be ignored while in RUN; the latched operands and the count SHALL be unaffected.
REQ-014 Each RUN cycle SHALL perform one restoring step: partial remainder = {rem[W-2:0], next dividend MSB}.
REQ-015 In each step, the partial remainder minus divisor SHALL be formed as a W+1-bit add of the partial remainder, the inverted divisor and carry-in 1.
REQ-016 In each step, a carry-out of 1 (no borrow) SHALL set the quotient bit to 1 and keep the difference; otherwise the quotient bit SHALL be 0 and the partial remainder is restored.
REQ-017 Quotient bits SHALL be produced MSB first, one per RUN cycle.
REQ-018 After exactly W RUN cycles the FSM SHALL enter DONE; the count SHALL wrap from W-1, and no step W+1 SHALL occur.
REQ-019 Latency SHALL be fixed: done is high in the cycle following the W-th clock edge after the accepting edge, independent of the operand values.
REQ-020 busy SHALL be 1 exactly in RUN and 0 in IDLE and DONE.
REQ-021 done SHALL be 1 exactly in DONE, for one cycle.
REQ-022 DONE SHALL return to IDLE unless start is high, in which case it SHALL go straight to RUN (back-to-back operation, no bubble).
REQ-023 quotient and remainder SHALL update only on entry to DONE and SHALL hold until the next entry to DONE.
REQ-024 If the latched divisor is 0, DONE SHALL present quotient = 0 and remainder = 0 with unchanged latency (LC4 convention).
REQ-025 Results SHALL satisfy dividend = quotient*divisor + remainder and remainder < divisor for every nonzero divisor, including dividend < divisor and dividend = 2^W-1.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, busy=0, done=0, quotient=0, remainder=0 and count=0, with no clock required.
REQ-027 Reset asserted mid-RUN SHALL abandon the division; no done pulse SHALL follow.
REQ-028 After rst_n deasserts, the first start SHALL be accepted normally on the next rising edge.

Verification
REQ-029 The bench SHALL cover: 100/7 -> one done pulse at latency 16, quotient=14, remainder=2, busy high for exactly 16 cycles.
REQ-030 The bench SHALL cover: 0xFFFF/0x0001 -> quotient=0xFFFF, remainder=0; and 3/10 -> quotient=0, remainder=3.
REQ-031 The bench SHALL cover: 5/0 -> quotient=0, remainder=0, done at latency 16.
REQ-032 The bench SHALL cover: start pulsed with 9/2 at cycles 4 and 9 after an accepted 100/7 -> result stays 14 r 2; no extra done pulse.
REQ-033 The bench SHALL cover: start held high with 1000/3 on the done cycle of the previous division -> busy the next cycle, then 333 r 1 16 cycles later.
REQ-034 The bench SHALL cover: rst_n low at RUN count 8 -> outputs 0 immediately; no done; a subsequent 50/5 gives 10 r 0.

Source files
------------

// File: rtl/lc4_seq_divider.sv
// Unsigned restoring divider: one quotient bit per cycle, MSB first, fixed W-cycle latency.
// A zero divisor yields quotient = 0 and remainder = 0 with the same latency.
module lc4_seq_divider #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(W - 1);

  state_t         state_q;
  logic [CW-1:0]  count_q;
  logic [W-1:0]   dvd_q;
  logic [W-1:0]   dsr_q;
  logic [W-1:0]   rem_q;
  logic [W-1:0]   quo_q;
  logic [W-1:0]   quotient_q;
  logic [W-1:0]   remainder_q;
  logic           busy_q;
  logic           done_q;

  logic [W-1:0]   partial_d;
  logic [W:0]     sum_d;
  logic           qbit_d;
  logic [W-1:0]   rem_d;
  logic [W-1:0]   quo_d;

  // One restoring step. The shift drops rem_q[W-1]; when that bit is set the true
  // partial remainder is >= 2^W > divisor, so the subtraction must succeed and the
  // low W bits of the sum are still the exact difference.
  always_comb begin
    partial_d = {rem_q[W-2:0], dvd_q[W-1]};
    sum_d     = {1'b0, partial_d} + {1'b0, ~dsr_q} + {{W{1'b0}}, 1'b1};
    qbit_d    = sum_d[W] | rem_q[W-1];
    rem_d     = qbit_d ? sum_d[W-1:0] : partial_d;
    quo_d     = {quo_q[W-2:0], qbit_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      dvd_q       <= '0;
      dsr_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            count_q <= '0;
            dvd_q   <= dividend;
            dsr_q   <= divisor;
            rem_q   <= '0;
            quo_q   <= '0;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        RUN: begin
          dvd_q <= {dvd_q[W-2:0], 1'b0};
          rem_q <= rem_d;
          quo_q <= quo_d;
          if (count_q == LAST_COUNT) begin
            state_q     <= DONE;
            count_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            quotient_q  <= (dsr_q == '0) ? '0 : quo_d;
            remainder_q <= (dsr_q == '0) ? '0 : rem_d;
          end else begin
            count_q <= count_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule

// File: tb/tb_lc4_seq_divider.sv
// Directed bench for lc4_seq_divider: results, fixed latency, ignored starts,
// back-to-back operation and asynchronous reset.
module tb_lc4_seq_divider;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;

  int checks;
  int errors;

  lc4_seq_divider #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called 1 time unit after a rising edge; returns after the accepting edge.
  task automatic start_div(input logic [W-1:0] a, input logic [W-1:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = $urandom_range(0, 65535);
    divisor  = $urandom_range(0, 65535);
  endtask

  // Counts edges until done is seen (bounded); lat = -1 on timeout.
  task automatic wait_done(output int lat, output int busy_cycles);
    lat = -1;
    busy_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        lat = i;
        break;
      end
      if (busy) busy_cycles++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
    checks++; if (quotient !== '0) begin errors++; $display("FAIL reset_quotient got %0h want 0", quotient); end
    checks++; if (remainder !== '0) begin errors++; $display("FAIL reset_remainder got %0h want 0", remainder); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    $display("reset released");
  endtask

  task automatic test_basic();
    int lat, bc;
    start_div(16'd100, 16'd7);
    wait_done(lat, bc);
    $display("div 100/7 -> q=%0d r=%0d lat=%0d busy=%0d", quotient, remainder, lat, bc);
    checks++; if (lat !== 16) begin errors++; $display("FAIL basic_latency got %0d want 16", lat); end
    checks++; if (bc !== 16) begin errors++; $display("FAIL basic_busy_cycles got %0d want 16", bc); end
    checks++; if (quotient !== 16'd14) begin errors++; $display("FAIL basic_quotient got %0d want 14", quotient); end
    checks++; if (remainder !== 16'd2) begin errors++; $display("FAIL basic_remainder got %0d want 2", remainder); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_single got %0b want 0", done); end
    checks++; if (quotient !== 16'd14) begin errors++; $display("FAIL basic_hold got %0d want 14", quotient); end
  endtask

  task automatic test_boundaries();
    logic [W-1:0] va [4] = '{16'hFFFF, 16'd3,  16'hFFFF, 16'hFFFF};
    logic [W-1:0] vb [4] = '{16'h0001, 16'd10, 16'hFFFE, 16'h8001};
    logic [W-1:0] eq [4] = '{16'hFFFF, 16'd0,  16'h0001, 16'h0001};
    logic [W-1:0] er [4] = '{16'h0000, 16'd3,  16'h0001, 16'h7FFE};
    int lat, bc;
    for (int i = 0; i < 4; i++) begin
      start_div(va[i], vb[i]);
      wait_done(lat, bc);
      $display("div %0h/%0h -> q=%0h r=%0h lat=%0d", va[i], vb[i], quotient, remainder, lat);
      checks++; if (lat !== 16) begin errors++; $display("FAIL bound%0d_latency got %0d want 16", i, lat); end
      checks++; if (quotient !== eq[i]) begin errors++; $display("FAIL bound%0d_quotient got %0h want %0h", i, quotient, eq[i]); end
      checks++; if (remainder !== er[i]) begin errors++; $display("FAIL bound%0d_remainder got %0h want %0h", i, remainder, er[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_div_zero();
    int lat, bc;
    start_div(16'd5, 16'd0);
    wait_done(lat, bc);
    $display("div 5/0 -> q=%0d r=%0d lat=%0d", quotient, remainder, lat);
    checks++; if (lat !== 16) begin errors++; $display("FAIL divzero_latency got %0d want 16", lat); end
    checks++; if (quotient !== '0) begin errors++; $display("FAIL divzero_quotient got %0h want 0", quotient); end
    checks++; if (remainder !== '0) begin errors++; $display("FAIL divzero_remainder got %0h want 0", remainder); end
    @(posedge clk); #1;
  endtask

  task automatic test_start_ignored();
    int lat, bc, pulses;
    start_div(16'd100, 16'd7);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; dividend = 16'd9; divisor = 16'd2;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; dividend = 16'd9; divisor = 16'd2;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, bc);
    $display("div 100/7 with ignored starts -> q=%0d r=%0d lat=%0d", quotient, remainder, lat + 9);
    checks++; if (lat + 9 !== 16) begin errors++; $display("FAIL ignored_latency got %0d want 16", lat + 9); end
    checks++; if (quotient !== 16'd14) begin errors++; $display("FAIL ignored_quotient got %0d want 14", quotient); end
    checks++; if (remainder !== 16'd2) begin errors++; $display("FAIL ignored_remainder got %0d want 2", remainder); end
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL ignored_extra_done got %0d want 0", pulses); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignored_idle_busy got %0b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    start_div(16'd100, 16'd7);
    wait_done(lat, bc);
    checks++; if (quotient !== 16'd14) begin errors++; $display("FAIL b2b_first_quotient got %0d want 14", quotient); end
    start = 1'b1; dividend = 16'd1000; divisor = 16'd3;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_next got %0b want 1", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_next got %0b want 0", done); end
    wait_done(lat, bc);
    $display("div 1000/3 back-to-back -> q=%0d r=%0d lat=%0d", quotient, remainder, lat);
    checks++; if (lat !== 16) begin errors++; $display("FAIL b2b_latency got %0d want 16", lat); end
    checks++; if (quotient !== 16'd333) begin errors++; $display("FAIL b2b_quotient got %0d want 333", quotient); end
    checks++; if (remainder !== 16'd1) begin errors++; $display("FAIL b2b_remainder got %0d want 1", remainder); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    int lat, bc, pulses;
    start_div(16'd100, 16'd7);
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %0b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got %0b want 0", done); end
    checks++; if (quotient !== '0) begin errors++; $display("FAIL midrst_quotient got %0d want 0", quotient); end
    checks++; if (remainder !== '0) begin errors++; $display("FAIL midrst_remainder got %0d want 0", remainder); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_no_done got %0d want 0", pulses); end
    start_div(16'd50, 16'd5);
    wait_done(lat, bc);
    $display("div 50/5 after reset -> q=%0d r=%0d lat=%0d", quotient, remainder, lat);
    checks++; if (lat !== 16) begin errors++; $display("FAIL midrst_latency got %0d want 16", lat); end
    checks++; if (quotient !== 16'd10) begin errors++; $display("FAIL midrst_quotient2 got %0d want 10", quotient); end
    checks++; if (remainder !== 16'd0) begin errors++; $display("FAIL midrst_remainder2 got %0d want 0", remainder); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_boundaries();
    test_div_zero();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
